// File: rtl/vgafb_scangen_if.sv
// Stream bundle between the raster generator, its pixel source and the output FIFO.
// Latency: n/a (wires only).
// Backpressure: pix_ack tells the source a pixel was taken; out_ready stalls the output beat.
//
// Ports (master = generator side):
//   pix_valid/pix_data in, pix_ack out       upstream pixel stream
//   out_valid out, out_ready in              output beat handshake
//   out_data, out_hsync, out_vsync, out_de,
//   out_sof, out_sol, line_idx out           output beat payload and fetch line
interface vgafb_scangen_if #(
    parameter int CNT_WIDTH   = 12,
    parameter int PIXEL_WIDTH = 16
);
    logic                   pix_valid;
    logic [PIXEL_WIDTH-1:0] pix_data;
    logic                   pix_ack;
    logic                   out_valid;
    logic                   out_ready;
    logic [PIXEL_WIDTH-1:0] out_data;
    logic                   out_hsync;
    logic                   out_vsync;
    logic                   out_de;
    logic                   out_sof;
    logic                   out_sol;
    logic [CNT_WIDTH-1:0]   line_idx;

    modport master (
        input  pix_valid, pix_data, out_ready,
        output pix_ack, out_valid, out_data, out_hsync, out_vsync,
               out_de, out_sof, out_sol, line_idx
    );

    modport slave (
        output pix_valid, pix_data, out_ready,
        input  pix_ack, out_valid, out_data, out_hsync, out_vsync,
               out_de, out_sof, out_sol, line_idx
    );
endinterface

// File: rtl/vgafb_scangen.sv
// Programmable H/V raster walker merging an upstream pixel stream into blanking, one beat per position.
// Latency: one cycle from an advance to the registered output beat.
// Backpressure: a held beat (out_valid & ~out_ready) freezes raster and outputs; a starved active pixel stalls the raster.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   en                        generator enable; low parks the raster at (0,0) and tracks cfg
//   cfg_h*/cfg_v*, cfg_dscan  raster timing (scan = last count) and line-doubling mode
//   bus (master)              pixel input, output beat stream and line_idx
module vgafb_scangen #(
    parameter int CNT_WIDTH   = 12,
    parameter int PIXEL_WIDTH = 16,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] cfg_hres,
    input  logic [CNT_WIDTH-1:0] cfg_hsync_start,
    input  logic [CNT_WIDTH-1:0] cfg_hsync_end,
    input  logic [CNT_WIDTH-1:0] cfg_hscan,
    input  logic [CNT_WIDTH-1:0] cfg_vres,
    input  logic [CNT_WIDTH-1:0] cfg_vsync_start,
    input  logic [CNT_WIDTH-1:0] cfg_vsync_end,
    input  logic [CNT_WIDTH-1:0] cfg_vscan,
    input  logic                 cfg_dscan,
    vgafb_scangen_if.master      bus
);

    // Idle (inactive) level of each sync output.
    localparam logic HS_IDLE = ~HSYNC_POL;
    localparam logic VS_IDLE = ~VSYNC_POL;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef struct packed {
        logic [CNT_WIDTH-1:0] hres;
        logic [CNT_WIDTH-1:0] hsync_start;
        logic [CNT_WIDTH-1:0] hsync_end;
        logic [CNT_WIDTH-1:0] hscan;
        logic [CNT_WIDTH-1:0] vres;
        logic [CNT_WIDTH-1:0] vsync_start;
        logic [CNT_WIDTH-1:0] vsync_end;
        logic [CNT_WIDTH-1:0] vscan;
        logic                 dscan;
    } cfg_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cfg_t                   cfg_q, cfg_d;        // shadow timing used by the raster
    logic                   load_pend_q;         // shadows not yet loaded since reset
    logic [CNT_WIDTH-1:0]   h_q, h_d;
    logic [CNT_WIDTH-1:0]   v_q, v_d;
    logic [CNT_WIDTH-1:0]   lidx_q, lidx_d;
    logic                   ovld_q, ovld_d;
    logic [PIXEL_WIDTH-1:0] odata_q, odata_d;
    logic                   ode_q, ode_d;
    logic                   ohs_q, ohs_d;
    logic                   ovs_q, ovs_d;
    logic                   osof_q, osof_d;
    logic                   osol_q, osol_d;

    // ------------------------------------------------------------------
    // Position decode and handshake
    // ------------------------------------------------------------------
    cfg_t cfg_in;
    logic run;
    logic act, hs, vs;
    logic h_last, v_last;
    logic slot, adv, cfg_load;

    always_comb begin
        cfg_in.hres        = cfg_hres;
        cfg_in.hsync_start = cfg_hsync_start;
        cfg_in.hsync_end   = cfg_hsync_end;
        cfg_in.hscan       = cfg_hscan;
        cfg_in.vres        = cfg_vres;
        cfg_in.vsync_start = cfg_vsync_start;
        cfg_in.vsync_end   = cfg_vsync_end;
        cfg_in.vscan       = cfg_vscan;
        cfg_in.dscan       = cfg_dscan;
    end

    // The first clock after reset only captures the shadows; walking the
    // raster on the reset-value timing would emit a bogus origin beat.
    assign run = en & ~load_pend_q;

    assign act = (h_q < cfg_q.hres) & (v_q < cfg_q.vres);
    // start >= end makes both ranges empty, i.e. no pulse.
    assign hs  = (h_q >= cfg_q.hsync_start) & (h_q < cfg_q.hsync_end);
    assign vs  = (v_q >= cfg_q.vsync_start) & (v_q < cfg_q.vsync_end);

    assign h_last = (h_q == cfg_q.hscan);
    assign v_last = (v_q == cfg_q.vscan);

    // The output register can take a new beat when empty or draining now.
    assign slot = ~ovld_q | bus.out_ready;
    // Blank positions never wait for the pixel source.
    assign adv  = run & slot & (~act | bus.pix_valid);
    assign bus.pix_ack = run & slot & act & bus.pix_valid;

    // Shadows follow cfg while parked and are re-armed only as the final
    // position of a frame is emitted, so a frame always uses one timing set.
    assign cfg_load = ~run | (adv & h_last & v_last);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        cfg_d   = cfg_q;
        h_d     = h_q;
        v_d     = v_q;
        lidx_d  = lidx_q;
        ovld_d  = ovld_q;
        odata_d = odata_q;
        ode_d   = ode_q;
        ohs_d   = ohs_q;
        ovs_d   = ovs_q;
        osof_d  = osof_q;
        osol_d  = osol_q;

        if (cfg_load) begin
            cfg_d = cfg_in;
        end

        if (!run) begin
            h_d    = '0;
            v_d    = '0;
            lidx_d = '0;
        end else if (adv) begin
            h_d = h_last ? '0 : h_q + CNT_ONE;
            if (h_last) begin
                v_d    = v_last ? '0 : v_q + CNT_ONE;
                // Double-scan presents every upstream line twice.
                lidx_d = cfg_q.dscan ? (v_d >> 1) : v_d;
            end
        end

        if (adv) begin
            ovld_d  = 1'b1;
            odata_d = act ? bus.pix_data : '0;
            ode_d   = act;
            ohs_d   = hs ^ HS_IDLE;
            ovs_d   = vs ^ VS_IDLE;
            osof_d  = (h_q == '0) & (v_q == '0);
            osol_d  = (h_q == '0);
        end else if (bus.out_ready) begin
            // Beat drained with nothing to replace it; payload is left as-is.
            ovld_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cfg_q       <= '0;
            load_pend_q <= 1'b1;
            h_q         <= '0;
            v_q         <= '0;
            lidx_q      <= '0;
            ovld_q      <= 1'b0;
            odata_q     <= '0;
            ode_q       <= 1'b0;
            ohs_q       <= HS_IDLE;
            ovs_q       <= VS_IDLE;
            osof_q      <= 1'b0;
            osol_q      <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            load_pend_q <= 1'b0;
            h_q         <= h_d;
            v_q         <= v_d;
            lidx_q      <= lidx_d;
            ovld_q      <= ovld_d;
            odata_q     <= odata_d;
            ode_q       <= ode_d;
            ohs_q       <= ohs_d;
            ovs_q       <= ovs_d;
            osof_q      <= osof_d;
            osol_q      <= osol_d;
        end
    end

    assign bus.out_valid = ovld_q;
    assign bus.out_data  = odata_q;
    assign bus.out_de    = ode_q;
    assign bus.out_hsync = ohs_q;
    assign bus.out_vsync = ovs_q;
    assign bus.out_sof   = osof_q;
    assign bus.out_sol   = osol_q;
    assign bus.line_idx  = lidx_q;

endmodule

// File: tb/tb_vgafb_scangen.sv
module tb_vgafb_scangen;
    localparam int CW = 12;
    localparam int PW = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          en;
    logic [CW-1:0] cfg_hres, cfg_hsync_start, cfg_hsync_end, cfg_hscan;
    logic [CW-1:0] cfg_vres, cfg_vsync_start, cfg_vsync_end, cfg_vscan;
    logic          cfg_dscan;

    vgafb_scangen_if #(.CNT_WIDTH(CW), .PIXEL_WIDTH(PW)) bus ();
    vgafb_scangen_if #(.CNT_WIDTH(CW), .PIXEL_WIDTH(PW)) bus2 ();

    // Second instance built with active-high hsync, fed identically.
    assign bus2.pix_valid = bus.pix_valid;
    assign bus2.pix_data  = bus.pix_data;
    assign bus2.out_ready = bus.out_ready;

    vgafb_scangen #(.CNT_WIDTH(CW), .PIXEL_WIDTH(PW), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
        .cfg_hres(cfg_hres), .cfg_hsync_start(cfg_hsync_start),
        .cfg_hsync_end(cfg_hsync_end), .cfg_hscan(cfg_hscan),
        .cfg_vres(cfg_vres), .cfg_vsync_start(cfg_vsync_start),
        .cfg_vsync_end(cfg_vsync_end), .cfg_vscan(cfg_vscan),
        .cfg_dscan(cfg_dscan), .bus(bus)
    );

    vgafb_scangen #(.CNT_WIDTH(CW), .PIXEL_WIDTH(PW), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)) dut_hpos (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
        .cfg_hres(cfg_hres), .cfg_hsync_start(cfg_hsync_start),
        .cfg_hsync_end(cfg_hsync_end), .cfg_hscan(cfg_hscan),
        .cfg_vres(cfg_vres), .cfg_vsync_start(cfg_vsync_start),
        .cfg_vsync_end(cfg_vsync_end), .cfg_vscan(cfg_vscan),
        .cfg_dscan(cfg_dscan), .bus(bus2)
    );

    always #5 sys_clk = ~sys_clk;

    // hs/vs hold the active (asserted) state, independent of polarity.
    typedef struct packed {
        logic [PW-1:0] data;
        logic          de;
        logic          hs;
        logic          vs;
        logic          sof;
        logic          sol;
        logic [CW-1:0] lidx;
    } exp_t;

    exp_t expq[$];
    int   n_vec, n_err;
    int   exp_k, pix_idx;

    // Stimulus schedule for run_stream (-1 = unused)
    int            sch_rdy_beat, sch_rdy_len;
    int            sch_pv_ack, sch_pv_len;
    int            sch_pv2_ack, sch_pv2_len;
    int            sch_cfg_beat;
    logic [CW-1:0] sch_cfg_hres;

    // Results of the last run_stream
    int            r_de, r_ack, r_sof, r_sol, r_pv2_beats;
    logic          r_first_sof;
    logic [CW-1:0] r_sol_lidx[$];

    function automatic logic [PW-1:0] pix_f(input int k);
        int t;
        t = k * 257 + 4660;
        return t[PW-1:0];
    endfunction

    task automatic set_basic_cfg();
        cfg_hres = 12'd4;  cfg_hsync_start = 12'd5; cfg_hsync_end = 12'd6; cfg_hscan = 12'd7;
        cfg_vres = 12'd2;  cfg_vsync_start = 12'd2; cfg_vsync_end = 12'd2; cfg_vscan = 12'd3;
        cfg_dscan = 1'b0;
    endtask

    // Expected beats of one frame in raster order; line_idx is the value
    // registered after the beat's advance, i.e. that of the next position.
    task automatic push_frame(input int hres, input int hss, input int hse, input int hscan,
                              input int vres, input int vss, input int vse, input int vscan,
                              input bit dscan);
        exp_t e;
        int   vn;
        for (int v = 0; v <= vscan; v++) begin
            for (int h = 0; h <= hscan; h++) begin
                e.de   = (h < hres) && (v < vres);
                e.data = e.de ? pix_f(exp_k) : '0;
                if (e.de) exp_k++;
                e.hs   = (h >= hss) && (h < hse);
                e.vs   = (v >= vss) && (v < vse);
                e.sof  = (h == 0) && (v == 0);
                e.sol  = (h == 0);
                vn     = (h == hscan) ? ((v == vscan) ? 0 : v + 1) : v;
                e.lidx = CW'(dscan ? (vn >> 1) : vn);
                expq.push_back(e);
            end
        end
    endtask

    // Park the generator, drain any pending beat and restart the pixel source.
    task automatic park();
        en            = 1'b0;
        bus.out_ready = 1'b1;
        bus.pix_valid = 1'b1;
        sch_rdy_beat = -1; sch_rdy_len = 0;
        sch_pv_ack   = -1; sch_pv_len  = 0;
        sch_pv2_ack  = -1; sch_pv2_len = 0;
        sch_cfg_beat = -1; sch_cfg_hres = '0;
        repeat (4) @(posedge sys_clk);
        #1;
        expq.delete();
        exp_k        = 0;
        pix_idx      = 0;
        bus.pix_data = pix_f(0);
    endtask

    // Runs the stream until n_beats beats are accepted, popping the scoreboard
    // per beat and applying the schedule; inputs change only at posedge+1.
    task automatic run_stream(input int n_beats, input int budget);
        int   beats, cyc, rdy_left, pv_left, pv2_left;
        bit   rdy_done, pv_done, pv2_done, cfg_done, saw_idle, snap_ok, ack_now;
        exp_t e, obs, snap;
        beats = 0; cyc = 0; rdy_left = 0; pv_left = 0; pv2_left = 0;
        rdy_done = 0; pv_done = 0; pv2_done = 0; cfg_done = 0; saw_idle = 0; snap_ok = 0;
        snap = '0;
        r_de = 0; r_ack = 0; r_sof = 0; r_sol = 0; r_pv2_beats = 0; r_first_sof = 1'b0;
        r_sol_lidx.delete();
        while (beats < n_beats) begin
            if (cyc >= budget) begin
                n_vec++; n_err++;
                $display("FAIL run_timeout: got %0d beats, need %0d", beats, n_beats);
                break;
            end
            @(negedge sys_clk);
            cyc++;
            ack_now  = (bus.pix_ack === 1'b1);
            obs.data = bus.out_data;
            obs.de   = bus.out_de;
            obs.hs   = ~bus.out_hsync;
            obs.vs   = ~bus.out_vsync;
            obs.sof  = bus.out_sof;
            obs.sol  = bus.out_sol;
            obs.lidx = bus.line_idx;
            if (rdy_left > 0) begin
                if (!snap_ok) begin snap = obs; snap_ok = 1; end
                n_vec++;
                if (bus.out_valid !== 1'b1 || obs !== snap || bus.pix_ack !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_hold: got vld=%b ack=%b beat=%h, need vld=1 ack=0 beat=%h",
                             bus.out_valid, bus.pix_ack, obs, snap);
                end
            end
            if (pv_left > 0 && bus.out_valid === 1'b0) saw_idle = 1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (pv2_left > 0) r_pv2_beats++;
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat: got beat %h, need none", obs);
                end else begin
                    e = expq.pop_front();
                    if (obs !== e || bus2.out_hsync !== e.hs) begin
                        n_err++;
                        $display("FAIL beat%0d: got %h hs_pos=%b, need %h hs_pos=%b",
                                 beats, obs, bus2.out_hsync, e, e.hs);
                    end
                end
                if (beats == 0) r_first_sof = bus.out_sof;
                if (bus.out_de === 1'b1) r_de++;
                if (bus.out_sof === 1'b1) r_sof++;
                if (bus.out_sol === 1'b1) begin r_sol++; r_sol_lidx.push_back(bus.line_idx); end
                beats++;
            end
            // An ack beside the final beat already belongs to the following frame.
            if (ack_now && beats < n_beats) r_ack++;

            @(posedge sys_clk);
            #1;
            if (ack_now) begin
                pix_idx++;
                bus.pix_data = pix_f(pix_idx);
            end
            if (rdy_left > 0) begin
                rdy_left--;
                if (rdy_left == 0) bus.out_ready = 1'b1;
            end else if (!rdy_done && sch_rdy_beat >= 0 && beats == sch_rdy_beat) begin
                bus.out_ready = 1'b0; rdy_left = sch_rdy_len; rdy_done = 1;
            end
            if (pv_left > 0) begin
                pv_left--;
                if (pv_left == 0) begin
                    bus.pix_valid = 1'b1;
                    n_vec++;
                    if (!saw_idle) begin
                        n_err++;
                        $display("FAIL starve_idle: got out_valid never low, need a drop while starved");
                    end
                end
            end else if (!pv_done && sch_pv_ack >= 0 && r_ack == sch_pv_ack) begin
                bus.pix_valid = 1'b0; pv_left = sch_pv_len; pv_done = 1;
            end else if (pv2_left > 0) begin
                pv2_left--;
                if (pv2_left == 0) bus.pix_valid = 1'b1;
            end else if (!pv2_done && sch_pv2_ack >= 0 && r_ack == sch_pv2_ack) begin
                bus.pix_valid = 1'b0; pv2_left = sch_pv2_len; pv2_done = 1;
            end
            if (!cfg_done && sch_cfg_beat >= 0 && beats == sch_cfg_beat) begin
                cfg_hres = sch_cfg_hres; cfg_done = 1;
            end
        end
        bus.out_ready = 1'b1;
        bus.pix_valid = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({bus.out_valid, bus.out_data, bus.out_de, bus.out_sof, bus.out_sol, bus.out_hsync,
             bus2.out_hsync, bus.out_vsync, bus.pix_ack, bus.line_idx}
            !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000}) begin
            n_err++;
            $display("FAIL reset_state: got vld=%b dat=%h de=%b sof=%b sol=%b hs=%b hs_pos=%b vs=%b ack=%b li=%h, need 0 0000 0 0 0 1 0 1 0 000",
                     bus.out_valid, bus.out_data, bus.out_de, bus.out_sof, bus.out_sol,
                     bus.out_hsync, bus2.out_hsync, bus.out_vsync, bus.pix_ack, bus.line_idx);
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.pix_ack !== 1'b0 || bus.line_idx !== 12'h000) begin
            n_err++;
            $display("FAIL disabled_idle: got vld=%b ack=%b li=%h, need vld=0 ack=0 li=000",
                     bus.out_valid, bus.pix_ack, bus.line_idx);
        end
    endtask

    task automatic test_basic_frame();
        set_basic_cfg();
        park();
        push_frame(4, 5, 6, 7, 2, 2, 2, 3, 1'b0);
        push_frame(4, 5, 6, 7, 2, 2, 2, 3, 1'b0);
        en = 1'b1;
        run_stream(64, 400);
        n_vec++;
        if (r_de !== 16 || r_sof !== 2 || r_sol !== 8 || r_ack !== 16) begin
            n_err++;
            $display("FAIL basic_counts: got de=%0d sof=%0d sol=%0d ack=%0d, need 16 2 8 16",
                     r_de, r_sof, r_sol, r_ack);
        end
    endtask

    task automatic test_backpressure();
        set_basic_cfg();
        park();
        push_frame(4, 5, 6, 7, 2, 2, 2, 3, 1'b0);
        sch_rdy_beat = 2; sch_rdy_len = 3;
        en = 1'b1;
        run_stream(32, 300);
        n_vec++;
        if (r_ack !== 8 || expq.size() !== 0) begin
            n_err++;
            $display("FAIL stall_acks: got ack=%0d left=%0d, need ack=8 left=0", r_ack, expq.size());
        end
    endtask

    task automatic test_starve();
        set_basic_cfg();
        park();
        push_frame(4, 5, 6, 7, 2, 2, 2, 3, 1'b0);
        sch_pv_ack  = 2; sch_pv_len  = 5;
        sch_pv2_ack = 4; sch_pv2_len = 4;
        en = 1'b1;
        run_stream(32, 300);
        n_vec++;
        if (r_pv2_beats !== 4) begin
            n_err++;
            $display("FAIL blank_no_pix: got %0d beats while pix_valid low in blanking, need 4", r_pv2_beats);
        end
        n_vec++;
        if (r_ack !== 8 || expq.size() !== 0) begin
            n_err++;
            $display("FAIL starve_acks: got ack=%0d left=%0d, need ack=8 left=0", r_ack, expq.size());
        end
    endtask

    task automatic test_cfg_shadow();
        set_basic_cfg();
        park();
        push_frame(4, 5, 6, 7, 2, 2, 2, 3, 1'b0);
        push_frame(6, 5, 6, 7, 2, 2, 2, 3, 1'b0);
        sch_cfg_beat = 11; sch_cfg_hres = 12'd6;
        en = 1'b1;
        run_stream(64, 400);
        n_vec++;
        if (r_de !== 20 || expq.size() !== 0) begin
            n_err++;
            $display("FAIL shadow_de: got de=%0d left=%0d, need de=20 left=0", r_de, expq.size());
        end
    endtask

    task automatic test_dscan();
        logic [CW-1:0] want [4];
        want[0] = 12'd0; want[1] = 12'd0; want[2] = 12'd1; want[3] = 12'd1;
        set_basic_cfg();
        cfg_vres  = 12'd4;
        cfg_dscan = 1'b1;
        park();
        push_frame(4, 5, 6, 7, 4, 2, 2, 3, 1'b1);
        en = 1'b1;
        run_stream(32, 300);
        n_vec++;
        if (r_sol_lidx.size() !== 4 || r_de !== 16) begin
            n_err++;
            $display("FAIL dscan_lines: got sol=%0d de=%0d, need sol=4 de=16", r_sol_lidx.size(), r_de);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (r_sol_lidx[i] !== want[i]) begin
                    n_err++;
                    $display("FAIL dscan_idx%0d: got %0d, need %0d", i, r_sol_lidx[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        set_basic_cfg();
        park();
        push_frame(4, 5, 6, 7, 2, 2, 2, 3, 1'b0);
        en = 1'b1;
        run_stream(5, 100);
        bus.out_ready = 1'b0;
        @(posedge sys_clk); #1;
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL prereset_valid: got vld=%b, need 1", bus.out_valid);
        end
        #3;
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_data, bus.out_de, bus.out_sof, bus.out_sol, bus.out_hsync,
             bus2.out_hsync, bus.out_vsync, bus.pix_ack, bus.line_idx}
            !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000}) begin
            n_err++;
            $display("FAIL async_reset: got vld=%b dat=%h de=%b sof=%b sol=%b hs=%b hs_pos=%b vs=%b ack=%b li=%h, need 0 0000 0 0 0 1 0 1 0 000",
                     bus.out_valid, bus.out_data, bus.out_de, bus.out_sof, bus.out_sol,
                     bus.out_hsync, bus2.out_hsync, bus.out_vsync, bus.pix_ack, bus.line_idx);
        end
        @(posedge sys_clk); #1;
        expq.delete();
        exp_k        = 0;
        pix_idx      = 0;
        bus.pix_data = pix_f(0);
        push_frame(4, 5, 6, 7, 2, 2, 2, 3, 1'b0);
        bus.out_ready = 1'b1;
        sys_rst_n     = 1'b1;
        run_stream(32, 300);
        n_vec++;
        if (r_first_sof !== 1'b1 || expq.size() !== 0) begin
            n_err++;
            $display("FAIL restart_sof: got sof=%b left=%0d, need sof=1 left=0", r_first_sof, expq.size());
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_k = 0; pix_idx = 0;
        sys_rst_n     = 1'b0;
        en            = 1'b0;
        bus.pix_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.pix_data  = pix_f(0);
        set_basic_cfg();
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_starve();
        test_cfg_shadow();
        test_dscan();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
